bullet: RTL and testbench

//  Bullet engine for one player: consumes bullet_fire/bullet_direction/pos_x/pos_y from that player's tank.

---
 rtl/bullet.sv | 176 +++++++++++++++++
 tb/tb_bullet.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet.sv
// Single-bullet engine for one player: spawns on a fire edge, steps 1 px per
// MOVE_TIME+1 cycles, and dies on a wall tile, off-map, or on the enemy tank.
module bullet #(
    parameter int unsigned PLAYER_INDEX = 0,
    parameter int unsigned MOVE_TIME    = 200000,
    parameter int unsigned RELOAD_TIME  = 800000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_over,
    input  logic        fire,
    input  logic [1:0]  fire_dir,
    input  logic [9:0]  tank_x,
    input  logic [9:0]  tank_y,
    input  logic [9:0]  enemy_x,
    input  logic [9:0]  enemy_y,
    input  logic        enemy_active,
    output logic [3:0]  wall_x_idx,
    output logic [3:0]  wall_y_idx,
    input  logic        wall_hit,
    output logic        killed,
    output logic [31:0] bullet_state
);

    localparam logic [19:0] MOVE_LOAD   = 20'(MOVE_TIME);
    localparam logic [19:0] RELOAD_LOAD = 20'(RELOAD_TIME);
    localparam logic [2:0]  OWNER_ID    = 3'(PLAYER_INDEX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLY,
        S_RELOAD
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_fire_d;
    logic        r_killed, w_killed_next;
    logic        r_active, w_active_next;
    logic [9:0]  r_x, w_x_next;
    logic [9:0]  r_y, w_y_next;
    logic [1:0]  r_dir, w_dir_next;
    logic [19:0] r_move_cnt, w_move_next;
    logic [19:0] r_rel_cnt, w_rel_next;

    logic        w_fire_req;
    logic [9:0]  w_spawn_x, w_spawn_y;
    logic [9:0]  w_step_x, w_step_y;
    logic [9:0]  w_probe_x, w_probe_y;
    logic        w_blocked;
    logic        w_hit;

    assign w_fire_req = fire & ~r_fire_d;

    always_comb begin
        w_spawn_x = tank_x + 10'd12;
        w_spawn_y = tank_y - 10'd8;
        case (fire_dir)
            2'b00: begin w_spawn_x = tank_x + 10'd12; w_spawn_y = tank_y - 10'd8;  end
            2'b01: begin w_spawn_x = tank_x + 10'd12; w_spawn_y = tank_y + 10'd32; end
            2'b10: begin w_spawn_x = tank_x - 10'd8;  w_spawn_y = tank_y + 10'd12; end
            2'b11: begin w_spawn_x = tank_x + 10'd32; w_spawn_y = tank_y + 10'd12; end
        endcase
    end

    always_comb begin
        w_step_x = r_x;
        w_step_y = r_y;
        case (r_dir)
            2'b00: w_step_y = r_y - 10'd1;
            2'b01: w_step_y = r_y + 10'd1;
            2'b10: w_step_x = r_x - 10'd1;
            2'b11: w_step_x = r_x + 10'd1;
        endcase
    end

    // Probe the centre of the 8x8 box at the next position; an underflowed
    // coordinate wraps high and lands in the off-map half.
    assign w_probe_x = w_step_x + 10'd4;
    assign w_probe_y = w_step_y + 10'd4;
    assign w_blocked = wall_hit | (w_probe_x >= 10'd512) | (w_probe_y >= 10'd512);

    assign wall_x_idx = (r_state == S_FLY) ? w_probe_x[8:5] : 4'd0;
    assign wall_y_idx = (r_state == S_FLY) ? w_probe_y[8:5] : 4'd0;

    assign w_hit = enemy_active
                 && (r_x < enemy_x + 10'd32) && (enemy_x < r_x + 10'd8)
                 && (r_y < enemy_y + 10'd32) && (enemy_y < r_y + 10'd8);

    // NOTE: every next-value gets a default before the case, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next  = r_state;
        w_killed_next = 1'b0;
        w_active_next = r_active;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_dir_next    = r_dir;
        w_move_next   = r_move_cnt;
        w_rel_next    = r_rel_cnt;

        if (!game_over) begin
            case (r_state)
                S_IDLE: begin
                    if (w_fire_req) begin
                        w_state_next  = S_FLY;
                        w_dir_next    = fire_dir;
                        w_move_next   = MOVE_LOAD;
                        w_active_next = 1'b1;
                        w_x_next      = w_spawn_x;
                        w_y_next      = w_spawn_y;
                    end
                end
                S_FLY: begin
                    if (w_hit) begin
                        w_killed_next = 1'b1;
                        w_active_next = 1'b0;
                        w_state_next  = S_RELOAD;
                        w_rel_next    = RELOAD_LOAD;
                    end else if (r_move_cnt != 20'd0) begin
                        w_move_next = r_move_cnt - 20'd1;
                    end else if (w_blocked) begin
                        w_active_next = 1'b0;
                        w_state_next  = S_RELOAD;
                        w_rel_next    = RELOAD_LOAD;
                    end else begin
                        w_x_next    = w_step_x;
                        w_y_next    = w_step_y;
                        w_move_next = MOVE_LOAD;
                    end
                end
                S_RELOAD: begin
                    // Leaving on the 1->0 decrement keeps RELOAD exactly RELOAD_TIME cycles long.
                    if (r_rel_cnt <= 20'd1) begin
                        w_rel_next   = 20'd0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_rel_next = r_rel_cnt - 20'd1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and covers every state register,
        // so a reset mid-flight aborts the bullet like a cold start.
        if (reset) begin
            r_state    <= S_IDLE;
            r_fire_d   <= 1'b0;
            r_killed   <= 1'b0;
            r_active   <= 1'b0;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_dir      <= 2'b00;
            r_move_cnt <= 20'd0;
            r_rel_cnt  <= 20'd0;
        end else begin
            r_state    <= w_state_next;
            r_fire_d   <= fire;
            r_killed   <= w_killed_next;
            r_active   <= w_active_next;
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_dir      <= w_dir_next;
            r_move_cnt <= w_move_next;
            r_rel_cnt  <= w_rel_next;
        end
    end

    assign killed       = r_killed;
    assign bullet_state = {1'b0, 2'b11, r_active, r_x, r_y, r_dir, 3'b001, OWNER_ID};

endmodule

// File: tb/tb_bullet.sv
// Bench for bullet: timestamp-based reference model checked every cycle,
// directed scenarios with hand-computed values, then randomized play.
`timescale 1ns/1ps
module tb_bullet;

    localparam int MT = 2;
    localparam int RT = 4;
    localparam int PI = 1;
    localparam logic [31:0] RESET_WORD = 32'h6000_0009;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        game_over = 1'b0;
    logic        fire = 1'b0;
    logic [1:0]  fire_dir = 2'b00;
    logic [9:0]  tank_x = '0, tank_y = '0, enemy_x = '0, enemy_y = '0;
    logic        enemy_active = 1'b0;
    logic [3:0]  wall_x_idx, wall_y_idx;
    logic        wall_hit;
    logic        killed;
    logic [31:0] bullet_state;

    int          wall_mode = 0;
    logic [255:0] wall_map = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // Map ROM stand-in: replies combinationally to the DUT's tile query.
    assign wall_hit = (wall_mode == 1) ? (wall_y_idx == 4'd1)
                    : (wall_mode == 2) ? wall_map[{wall_y_idx, wall_x_idx}] : 1'b0;

    bullet #(.PLAYER_INDEX(PI), .MOVE_TIME(MT), .RELOAD_TIME(RT)) dut (
        .clk(clk), .reset(reset), .game_over(game_over), .fire(fire),
        .fire_dir(fire_dir), .tank_x(tank_x), .tank_y(tank_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_active(enemy_active),
        .wall_x_idx(wall_x_idx), .wall_y_idx(wall_y_idx), .wall_hit(wall_hit),
        .killed(killed), .bullet_state(bullet_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input bit a, input logic [9:0] x, input logic [9:0] y,
                                         input logic [1:0] d);
        return {1'b0, 2'b11, a, x, y, d, 3'b001, 3'(PI)};
    endfunction

    function automatic bit wall_fn(input logic [3:0] xi, input logic [3:0] yi);
        if (wall_mode == 1) return (yi == 4'd1);
        if (wall_mode == 2) return wall_map[{yi, xi}];
        return 1'b0;
    endfunction

    function automatic bit overlap(input logic [9:0] bx, input logic [9:0] by,
                                   input logic [9:0] ex, input logic [9:0] ey);
        logic [9:0] ex_end, ey_end, bx_end, by_end;
        ex_end = ex + 10'd32; ey_end = ey + 10'd32;
        bx_end = bx + 10'd8;  by_end = by + 10'd8;
        return (bx < ex_end) && (ex < bx_end) && (by < ey_end) && (ey < by_end);
    endfunction

    // Reference model: bullet life expressed as timestamps on an "effective"
    // clock that only advances while the game is not frozen.
    bit         m_fly = 1'b0, m_kill = 1'b0, m_fire_d = 1'b0;
    logic [9:0] m_x = '0, m_y = '0;
    logic [1:0] m_dir = '0;
    int         t_eff = 0, t_spawn = 0, t_death = -100;

    always @(negedge clk) begin : model
        logic [9:0] nx, ny, px, py;
        logic [3:0] ewx, ewy;
        bit         req;
        nx = m_x; ny = m_y;
        case (m_dir)
            2'b00: ny = m_y - 10'd1;
            2'b01: ny = m_y + 10'd1;
            2'b10: nx = m_x - 10'd1;
            default: nx = m_x + 10'd1;
        endcase
        px = nx + 10'd4;
        py = ny + 10'd4;
        ewx = m_fly ? px[8:5] : 4'd0;
        ewy = m_fly ? py[8:5] : 4'd0;

        check("state_word", bullet_state, pack(m_fly, m_x, m_y, m_dir));
        check("killed", {31'd0, killed}, {31'd0, m_kill});
        check("wall_idx", {24'd0, wall_x_idx, wall_y_idx}, {24'd0, ewx, ewy});

        if (reset) begin
            m_fly = 0; m_kill = 0; m_fire_d = 0; m_x = '0; m_y = '0; m_dir = '0;
            t_eff = 0; t_spawn = 0; t_death = -100;
        end else begin
            req = fire && !m_fire_d;
            m_fire_d = fire;
            m_kill = 0;
            if (!game_over) begin
                t_eff++;
                if (m_fly) begin
                    if (enemy_active && overlap(m_x, m_y, enemy_x, enemy_y)) begin
                        m_kill = 1; m_fly = 0; t_death = t_eff;
                    end else if ((t_eff - t_spawn) % (MT + 1) == 0) begin
                        if (wall_fn(px[8:5], py[8:5]) || px >= 10'd512 || py >= 10'd512) begin
                            m_fly = 0; t_death = t_eff;
                        end else begin
                            m_x = nx; m_y = ny;
                        end
                    end
                end else if (req && t_eff > t_death + RT) begin
                    m_fly = 1; m_dir = fire_dir; t_spawn = t_eff;
                    case (fire_dir)
                        2'b00: begin m_x = tank_x + 10'd12; m_y = tank_y - 10'd8;  end
                        2'b01: begin m_x = tank_x + 10'd12; m_y = tank_y + 10'd32; end
                        2'b10: begin m_x = tank_x - 10'd8;  m_y = tank_y + 10'd12; end
                        default: begin m_x = tank_x + 10'd32; m_y = tank_y + 10'd12; end
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fire = 0; game_over = 0; reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        int  n, spawns;
        bit  prev_act, any_kill;
        logic [31:0] frozen;

        tick(); tick();
        check("reset_state", bullet_state, RESET_WORD);
        check("reset_killed", {31'd0, killed}, 32'd0);
        check("reset_widx", {24'd0, wall_x_idx, wall_y_idx}, 32'd0);
        reset = 0;

        // T1: spawn to the right and step every MT+1 cycles
        tank_x = 10'd64; tank_y = 10'd64; fire_dir = 2'b11; fire = 1;
        tick();
        check("t1_spawn", bullet_state, pack(1, 10'd96, 10'd76, 2'b11));
        tick(); tick();
        check("t1_hold", {22'd0, bullet_state[27:18]}, 32'd96);
        tick();
        check("t1_step", {22'd0, bullet_state[27:18]}, 32'd97);

        // T6a: reset mid-flight
        fire = 0; reset = 1;
        tick();
        check("t6_reset_word", bullet_state, RESET_WORD);
        check("t6_reset_killed", {31'd0, killed}, 32'd0);
        reset = 0;

        // T2: upward shot into a wall row, then reload window
        wall_mode = 1; fire_dir = 2'b00; fire = 1;
        tick();
        check("t2_spawn", bullet_state, pack(1, 10'd76, 10'd56, 2'b00));
        fire = 0;
        tick();
        check("t2_probe_idx", {24'd0, wall_x_idx, wall_y_idx}, 32'h21);
        tick(); tick();
        check("t2_wall_death", bullet_state, pack(0, 10'd76, 10'd56, 2'b00));
        tick();
        fire = 1; tick();
        check("t2_drop_early", {31'd0, bullet_state[28]}, 32'd0);
        fire = 0; tick();
        fire = 1; tick();
        check("t2_drop_last", {31'd0, bullet_state[28]}, 32'd0);
        fire = 0; tick();
        fire = 1; tick();
        check("t2_respawn", {31'd0, bullet_state[28]}, 32'd1);
        fire = 0; tick(); tick(); tick();
        check("t2_wall_death2", {31'd0, bullet_state[28]}, 32'd0);
        repeat (4) tick();
        fire = 1; tick();
        check("t2_reload_end", {31'd0, bullet_state[28]}, 32'd1);
        fire = 0;

        // T4: fire held high for 100 cycles spawns exactly once
        do_reset();
        fire = 1; spawns = 0; prev_act = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bullet_state[28] && !prev_act) spawns++;
            prev_act = bullet_state[28];
        end
        check("t4_one_spawn", spawns, 32'd1);
        fire = 0;

        // T3: enemy hit, single-cycle pulse
        do_reset();
        wall_mode = 0; fire_dir = 2'b11;
        enemy_x = 10'd128; enemy_y = 10'd72; enemy_active = 1;
        fire = 1; tick(); fire = 0;
        n = 0;
        while (!killed && n < 200) begin
            tick();
            n++;
        end
        check("t3_hit_latency", n, 32'd76);
        check("t3_hit_x", {22'd0, bullet_state[27:18]}, 32'd121);
        check("t3_hit_inactive", {31'd0, bullet_state[28]}, 32'd0);
        tick();
        check("t3_pulse_width", {31'd0, killed}, 32'd0);

        // T3b/T4b: inactive enemy is ignored, fire edges in flight ignored
        do_reset();
        enemy_active = 0; fire = 1; tick();
        any_kill = 0;
        for (int i = 1; i < 100; i++) begin
            fire = (i % 7 == 0);
            tick();
            if (killed) any_kill = 1;
        end
        check("t3_no_kill", {31'd0, any_kill}, 32'd0);
        check("t3_pass_x", {22'd0, bullet_state[27:18]}, 32'd129);
        check("t3_pass_active", {31'd0, bullet_state[28]}, 32'd1);

        // T5: freeze mid-flight with the enemy overlapping
        do_reset();
        enemy_active = 0; fire = 1; tick(); fire = 0;
        repeat (5) tick();
        check("t5_before", bullet_state, pack(1, 10'd97, 10'd76, 2'b11));
        frozen = bullet_state;
        game_over = 1; enemy_x = 10'd90; enemy_y = 10'd70; enemy_active = 1;
        any_kill = 0;
        for (int i = 0; i < 10; i++) begin
            fire = i[0];
            tick();
            if (killed) any_kill = 1;
        end
        check("t5_frozen", bullet_state, frozen);
        check("t5_no_kill", {31'd0, any_kill}, 32'd0);
        fire = 0; game_over = 0;
        tick();
        check("t5_resume_kill", {31'd0, killed}, 32'd1);
        check("t5_resume_word", bullet_state, pack(0, 10'd97, 10'd76, 2'b11));

        // T6b: hit and wall on the same cycle, hit wins
        do_reset();
        wall_mode = 1; enemy_active = 0; fire_dir = 2'b00; fire = 1;
        tick(); fire = 0;
        tick(); tick();
        enemy_x = 10'd70; enemy_y = 10'd40; enemy_active = 1;
        tick();
        check("t6_hit_wall_kill", {31'd0, killed}, 32'd1);
        check("t6_hit_wall_inactive", {31'd0, bullet_state[28]}, 32'd0);

        // Randomized play against a sparse random map
        do_reset();
        for (int k = 0; k < 256; k++) wall_map[k] = ($urandom_range(0, 7) == 0);
        wall_mode = 2;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 3) == 0) fire = ~fire;
            fire_dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) begin
                tank_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 480));
                tank_y = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(0, 480));
                enemy_x = tank_x + 10'($urandom_range(0, 160)) - 10'd80;
                enemy_y = tank_y + 10'($urandom_range(0, 160)) - 10'd80;
            end
            if ($urandom_range(0, 15) == 0) enemy_active = ($urandom_range(0, 3) != 0);
            game_over = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 1499) == 0);
            tick();
        end
        reset = 0; game_over = 0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
